// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider; the divider core sits on the slave side.
interface seq_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider: one trial subtraction per clock, MSB first, N iterations per operation.
// The N parameter must match the N of the connected seq_divider_if.
module seq_divider #(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [N-1:0]  div_q, div_d;
    logic [N:0]    part_q, part_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic          fits;

    always_comb begin
        shifted = {part_q[N-1:0], shift_q[N-1]};
        trial   = shifted - {1'b0, div_q};
        fits    = ~trial[N];

        state_d = state_q;
        shift_d = shift_q;
        div_d   = div_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        shift_d = bus.dividend;
                        div_d   = bus.divisor;
                        part_d  = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        // Division by zero skips iteration and reports the conventional all-ones quotient.
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                part_d  = fits ? trial : shifted;
                shift_d = {shift_q[N-2:0], fits};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    quot_d  = {shift_q[N-2:0], fits};
                    rem_d   = fits ? trial[N-1:0] : shifted[N-1:0];
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            div_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
